fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_defs.sv | 20 ++
 rtl/fifo_mem.sv | 32 +++
 rtl/fifo_param.sv | 98 +++++++++
 tb/tb_fifo_param.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_defs.sv
// Shared defaults and constant helpers for the parametrised FIFO.
package fifo_defs;

   localparam int DEF_DATA_SIZE = 8;
   localparam int DEF_MAIN_SIZE = 6;

   // Ceiling log2, usable in parameter expressions; clog2(1) is 0.
   function automatic int clog2(input int value);
      int res;
      int rem;
      res = 0;
      rem = value - 1;
      while (rem > 0) begin
         res = res + 1;
         rem = rem >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 6,
   parameter int AW    = 3
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: store the word on an accepted push.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read port: a same-edge write to rd_addr is not seen, so a full
   // read+write still returns the oldest word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: pointers, occupancy count, status
// flags and sticky error; storage lives in fifo_mem.
module fifo_param
   import fifo_defs::*;
#(
   parameter  int DATA_SIZE = DEF_DATA_SIZE,
   parameter  int MAIN_SIZE = DEF_MAIN_SIZE,
   localparam int CNT_W     = clog2(MAIN_SIZE + 1)
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 write,
   input  logic                 read,
   input  logic [DATA_SIZE-1:0] data_in_push,
   input  logic [CNT_W-1:0]     af_thresh,
   input  logic [CNT_W-1:0]     ae_thresh,
   input  logic                 err_clr,
   output logic [DATA_SIZE-1:0] data_out_pop,
   output logic [CNT_W-1:0]     fifo_count,
   output logic                 fifo_empty,
   output logic                 fifo_full,
   output logic                 almost_empty,
   output logic                 almost_full,
   output logic                 fifo_pause,
   output logic                 fifo_error
);

   localparam int                PTR_W    = clog2(MAIN_SIZE);
   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(MAIN_SIZE - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(MAIN_SIZE);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             rd_acc;
   logic             wr_acc;
   logic             op_rej;
   logic             err_q;

   // Pointers wrap at MAIN_SIZE-1 so any depth works, not just powers of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Status flags come only from the count register and the live thresholds.
   assign fifo_empty   = (count == '0);
   assign fifo_full    = (count == FULL_CNT);
   assign almost_full  = (count >= af_thresh);
   assign almost_empty = (count <= ae_thresh);
   assign fifo_pause   = almost_full;
   assign fifo_count   = count;
   assign fifo_error   = err_q;

   // A push into a full FIFO is allowed only when a pop frees a slot that edge.
   assign rd_acc = read && !fifo_empty;
   assign wr_acc = write && (!fifo_full || rd_acc);
   assign op_rej = (write && !wr_acc) || (read && !rd_acc);

   // Pointer and occupancy update; rejected operations leave everything alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
         if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky error: a new rejection wins over a clear in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        err_q <= 1'b0;
      else if (op_rej)  err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
   end

   fifo_mem #(
      .WIDTH (DATA_SIZE),
      .DEPTH (MAIN_SIZE),
      .AW    (PTR_W)
   ) u_mem (
      .clk     (clk),
      .rst     (reset),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (data_in_push),
      .rd_en   (rd_acc),
      .rd_addr (rd_ptr),
      .rd_data (data_out_pop)
   );

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: a depth-6 and a depth-5 instance, each checked
// against a queue-based reference model after every clock step.
module tb_fifo_param;

   logic clk;
   int   errors = 0;
   int   checks = 0;

   // Instance 0: MAIN_SIZE=6
   logic       rst0, wr0, rd0, clr0;
   logic [7:0] din0, dout0;
   logic [2:0] af0, ae0, cnt0;
   logic       emp0, ful0, aem0, afu0, pau0, err0;
   // Instance 1: MAIN_SIZE=5
   logic       rst1, wr1, rd1, clr1;
   logic [7:0] din1, dout1;
   logic [2:0] af1, ae1, cnt1;
   logic       emp1, ful1, aem1, afu1, pau1, err1;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] exp_dout [2];
   logic       exp_err  [2];

   fifo_param #(.DATA_SIZE(8), .MAIN_SIZE(6)) dut0 (
      .clk(clk), .reset(rst0), .write(wr0), .read(rd0), .data_in_push(din0),
      .af_thresh(af0), .ae_thresh(ae0), .err_clr(clr0), .data_out_pop(dout0),
      .fifo_count(cnt0), .fifo_empty(emp0), .fifo_full(ful0),
      .almost_empty(aem0), .almost_full(afu0), .fifo_pause(pau0), .fifo_error(err0)
   );

   fifo_param #(.DATA_SIZE(8), .MAIN_SIZE(5)) dut1 (
      .clk(clk), .reset(rst1), .write(wr1), .read(rd1), .data_in_push(din1),
      .af_thresh(af1), .ae_thresh(ae1), .err_clr(clr1), .data_out_pop(dout1),
      .fifo_count(cnt1), .fifo_empty(emp1), .fifo_full(ful1),
      .almost_empty(aem1), .almost_full(afu1), .fifo_pause(pau1), .fifo_error(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int depth(input int s);
      return (s == 0) ? 6 : 5;
   endfunction

   function automatic int msize(input int s);
      return (s == 0) ? q0.size() : q1.size();
   endfunction

   task automatic mclear(input int s);
      if (s == 0) q0.delete(); else q1.delete();
      exp_dout[s] = 8'h00;
      exp_err[s]  = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input int s, input string tag);
      logic [7:0] d;
      logic [2:0] c, af, ae;
      logic       e, f, aem, afu, p, er;
      int         sz;
      if (s == 0) begin
         d = dout0; c = cnt0; e = emp0; f = ful0; aem = aem0; afu = afu0;
         p = pau0; er = err0; af = af0; ae = ae0;
      end else begin
         d = dout1; c = cnt1; e = emp1; f = ful1; aem = aem1; afu = afu1;
         p = pau1; er = err1; af = af1; ae = ae1;
      end
      sz = msize(s);
      chk({tag, ".dout"},  32'(d),   32'(exp_dout[s]));
      chk({tag, ".count"}, 32'(c),   32'(sz));
      chk({tag, ".empty"}, 32'(e),   32'(sz == 0));
      chk({tag, ".full"},  32'(f),   32'(sz == depth(s)));
      chk({tag, ".aempty"},32'(aem), 32'(sz <= int'(ae)));
      chk({tag, ".afull"}, 32'(afu), 32'(sz >= int'(af)));
      chk({tag, ".pause"}, 32'(p),   32'(sz >= int'(af)));
      chk({tag, ".error"}, 32'(er),  32'(exp_err[s]));
   endtask

   // One clock of stimulus on instance s, model update, then full check.
   task automatic step(input int s, input bit w, input bit r, input logic [7:0] d,
                       input bit clr, input string tag);
      int sz;
      bit racc, wacc, rej;
      sz   = msize(s);
      racc = r && (sz != 0);
      wacc = w && ((sz != depth(s)) || racc);
      rej  = (w && !wacc) || (r && !racc);
      if (s == 0) begin wr0 = w; rd0 = r; din0 = d; clr0 = clr; end
      else        begin wr1 = w; rd1 = r; din1 = d; clr1 = clr; end
      @(posedge clk);
      if (racc) begin
         if (s == 0) exp_dout[s] = q0.pop_front(); else exp_dout[s] = q1.pop_front();
      end
      if (wacc) begin
         if (s == 0) q0.push_back(d); else q1.push_back(d);
      end
      if (rej)      exp_err[s] = 1'b1;
      else if (clr) exp_err[s] = 1'b0;
      #1;
      if (s == 0) begin wr0 = 0; rd0 = 0; clr0 = 0; end
      else        begin wr1 = 0; rd1 = 0; clr1 = 0; end
      check_all(s, tag);
   endtask

   initial begin
      rst0 = 1; wr0 = 0; rd0 = 0; clr0 = 0; din0 = 0; af0 = 3'd5; ae0 = 3'd1;
      rst1 = 1; wr1 = 0; rd1 = 0; clr1 = 0; din1 = 0; af1 = 3'd4; ae1 = 3'd1;
      mclear(0);
      mclear(1);
      #12;
      check_all(0, "reset0");
      check_all(1, "reset1");
      af0 = 3'd0;
      #1;
      check_all(0, "reset_af0");
      af0 = 3'd5;
      @(posedge clk); #1;
      rst0 = 0; rst1 = 0;

      // Fill to full; almost_full rises after the 5th word.
      for (int i = 0; i < 6; i++)
         step(0, 1, 0, 8'(17 * (i + 1)), 0, $sformatf("fill%0d", i));

      // Push into full FIFO is rejected, then the error is cleared.
      step(0, 1, 0, 8'h77, 0, "ovf");
      step(0, 0, 0, 8'h00, 1, "ovf_clr");

      // Full read+write: oldest out, count stays, 0xAA comes out last.
      step(0, 1, 1, 8'hAA, 0, "full_rw");
      for (int i = 0; i < 6; i++)
         step(0, 0, 1, 8'h00, 0, $sformatf("drain%0d", i));

      // Pop from empty is rejected; error set and clear in same cycle -> set.
      step(0, 0, 1, 8'h00, 1, "udf_setwins");
      step(0, 0, 0, 8'h00, 1, "udf_clr");

      // Empty read+write: write lands, read rejected.
      step(0, 1, 1, 8'h5C, 0, "empty_rw");
      step(0, 0, 1, 8'h00, 1, "read_5c");

      // Randomised traffic with occasional live threshold changes.
      for (int i = 0; i < 300; i++) begin
         if (i % 25 == 0) begin
            af0 = 3'($urandom_range(0, 7));
            ae0 = 3'($urandom_range(0, 7));
            #1;
            check_all(0, $sformatf("thr%0d", i));
         end
         step(0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              8'($urandom), ($urandom_range(0, 7) == 0), $sformatf("rnd0_%0d", i));
      end
      af0 = 3'd5; ae0 = 3'd1;

      // Asynchronous reset in the middle of a write cycle discards everything.
      while (msize(0) != 0) step(0, 0, 1, 8'h00, 1, "pre_rst_drain");
      for (int i = 0; i < 3; i++)
         step(0, 1, 0, 8'($urandom), 0, $sformatf("prerst%0d", i));
      wr0 = 1; din0 = 8'hEE;
      #2;
      rst0 = 1;
      #1;
      mclear(0);
      check_all(0, "async_rst");
      wr0 = 0;
      @(posedge clk); #1;
      rst0 = 0;
      check_all(0, "post_rst");
      step(0, 1, 0, 8'h3C, 0, "first_after_rst");
      step(0, 0, 1, 8'h00, 0, "first_read_after_rst");

      // Depth-5 instance: pointer wrap under continuous push/pop.
      for (int i = 0; i < 3; i++)
         step(1, 1, 0, 8'($urandom), 0, $sformatf("w5_fill%0d", i));
      for (int i = 0; i < 12; i++)
         step(1, 1, 1, 8'($urandom), 0, $sformatf("w5_rw%0d", i));
      for (int i = 0; i < 4; i++)
         step(1, 0, 1, 8'h00, 0, $sformatf("w5_drain%0d", i));
      for (int i = 0; i < 200; i++)
         step(1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              8'($urandom), ($urandom_range(0, 7) == 0), $sformatf("rnd1_%0d", i));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
